// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: rotates an active-low column strobe once per tick and
// debounces press and release of the highest-priority (lowest row) key.
module key_matrix_scan #(
   parameter logic [31:0] SCAN_NUM = 32'd50000,
   parameter logic [3:0]  DEB_NUM  = 4'd10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic [3:0] o_key,
   output logic       o_key_vld,
   output logic       o_key_held
);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HOLD, S_RELEASE} state_t;

   // Press threshold counts the SCAN sampling tick, so DEBOUNCE needs one fewer match.
   localparam logic [3:0] PRESS_THR = (DEB_NUM <= 4'd1) ? 4'd0 : DEB_NUM - 4'd1;

   state_t      state_q, state_d;
   logic [31:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]  sync1_q, sync2_q;
   logic [1:0]  col_q, col_d;
   logic [3:0]  cand_q, cand_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  key_q, key_d;
   logic        vld_q, vld_d;

   logic        tick;
   logic        any_low;
   logic [1:0]  row_idx;
   logic        cand_row_high;
   logic [4:0]  cnt_inc;

   assign tick          = (tick_cnt_q == SCAN_NUM - 32'd1);
   assign any_low       = ~&sync2_q;
   assign cand_row_high = sync2_q[cand_q[3:2]];
   assign cnt_inc       = {1'b0, cnt_q} + 5'd1;

   always_comb begin
      row_idx = 2'd0;
      // Descending walk so the lowest low row is the last (winning) assignment.
      for (int i = 3; i >= 0; i--) begin
         if (!sync2_q[i]) row_idx = 2'(i);
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
      col_d      = col_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      key_d      = key_q;
      vld_d      = 1'b0;

      if (tick) begin
         unique case (state_q)
            S_SCAN: begin
               if (any_low) begin
                  cand_d  = {row_idx, col_q};
                  cnt_d   = 4'd0;
                  state_d = S_DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
            S_DEBOUNCE: begin
               if (any_low && ({row_idx, col_q} == cand_q)) begin
                  if (cnt_inc >= {1'b0, PRESS_THR}) begin
                     key_d   = cand_q;
                     vld_d   = 1'b1;
                     state_d = S_HOLD;
                  end else begin
                     cnt_d = cnt_inc[3:0];
                  end
               end else begin
                  col_d   = col_q + 2'd1;
                  state_d = S_SCAN;
               end
            end
            S_HOLD: begin
               if (cand_row_high) begin
                  cnt_d   = 4'd0;
                  state_d = S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!cand_row_high) begin
                  state_d = S_HOLD;
               end else if (cnt_inc >= {1'b0, DEB_NUM}) begin
                  col_d   = col_q + 2'd1;
                  state_d = S_SCAN;
               end else begin
                  cnt_d = cnt_inc[3:0];
               end
            end
            default: state_d = S_SCAN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the reset is asynchronous.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: synchronizer resets to idle-high so no phantom press follows reset.
         sync1_q    <= 4'b1111;
         sync2_q    <= 4'b1111;
         state_q    <= S_SCAN;
         tick_cnt_q <= 32'd0;
         col_q      <= 2'd0;
         cand_q     <= 4'd0;
         cnt_q      <= 4'd0;
         key_q      <= 4'd0;
         vld_q      <= 1'b0;
      end else begin
         sync1_q    <= i_row;
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         col_q      <= col_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         key_q      <= key_d;
         vld_q      <= vld_d;
      end
   end

   assign o_col      = ~(4'b0001 << col_q);
   assign o_key      = key_q;
   assign o_key_vld  = vld_q;
   assign o_key_held = (state_q == S_HOLD) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with SCAN_NUM=4, DEB_NUM=3; a keypad
// model pulls a row low when its pressed column is being driven.
module tb_key_matrix_scan;

   logic       clk;
   logic       rst_n;
   logic [3:0] i_row;
   logic [3:0] o_col;
   logic [3:0] o_key;
   logic       o_key_vld;
   logic       o_key_held;

   logic [3:0] keys [4];
   int         n_cmp;
   int         n_err;
   int         vld_cnt;

   key_matrix_scan #(.SCAN_NUM(32'd4), .DEB_NUM(4'd3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_row      (i_row),
      .o_col      (o_col),
      .o_key      (o_key),
      .o_key_vld  (o_key_vld),
      .o_key_held (o_key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      i_row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         if (|(keys[r] & ~o_col)) i_row[r] = 1'b0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_cnt <= 0;
      else if (o_key_vld === 1'b1) vld_cnt <= vld_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (4 * n) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
      rst_n = 1'b0;
      clocks(3);
      check("rst_col", 32'(o_col), 32'hE);
      check("rst_key", 32'(o_key), 32'h0);
      check("rst_vld", 32'(o_key_vld), 32'h0);
      check("rst_held", 32'(o_key_held), 32'h0);
      rst_n = 1'b1;

      // Idle rotation, each column held four clocks.
      clocks(3);
      check("idle_col0_hold", 32'(o_col), 32'hE);
      clocks(1);
      check("idle_col1", 32'(o_col), 32'hD);
      check("idle_vld", 32'(o_key_vld), 32'h0);
      ticks(1);
      check("idle_col2", 32'(o_col), 32'hB);
      ticks(1);
      check("idle_col3", 32'(o_col), 32'h7);
      ticks(1);
      check("idle_wrap", 32'(o_col), 32'hE);
      check("idle_vld_cnt", 32'(vld_cnt), 32'd0);

      // Clean press of row2/col1.
      keys[2] = 4'b0010;
      ticks(1);
      check("p9_col1", 32'(o_col), 32'hD);
      ticks(1);
      check("p9_col_frozen", 32'(o_col), 32'hD);
      check("p9_not_held", 32'(o_key_held), 32'h0);
      ticks(1);
      check("p9_no_early_vld", 32'(o_key_vld), 32'h0);
      ticks(1);
      check("p9_vld", 32'(o_key_vld), 32'h1);
      check("p9_key", 32'(o_key), 32'h9);
      check("p9_held", 32'(o_key_held), 32'h1);
      clocks(1);
      check("p9_vld_one_clk", 32'(o_key_vld), 32'h0);
      clocks(3);
      ticks(2);
      check("p9_still_held", 32'(o_key_held), 32'h1);
      check("p9_hold_col", 32'(o_col), 32'hD);
      check("p9_vld_cnt", 32'(vld_cnt), 32'd1);
      keys[2] = 4'b0000;
      ticks(3);
      check("p9_rel_pending", 32'(o_key_held), 32'h1);
      ticks(1);
      check("p9_released", 32'(o_key_held), 32'h0);
      check("p9_rel_col_adv", 32'(o_col), 32'hB);
      check("p9_key_kept", 32'(o_key), 32'h9);

      // One-tick glitch on row1/col2 during DEBOUNCE.
      keys[1] = 4'b0100;
      ticks(1);
      keys[1] = 4'b0000;
      ticks(1);
      check("glitch_col_adv", 32'(o_col), 32'h7);
      check("glitch_key_kept", 32'(o_key), 32'h9);
      check("glitch_vld_cnt", 32'(vld_cnt), 32'd1);
      check("glitch_not_held", 32'(o_key_held), 32'h0);

      // Press row0/col3 then bounce on release.
      keys[0] = 4'b1000;
      ticks(3);
      check("p3_vld", 32'(o_key_vld), 32'h1);
      check("p3_key", 32'(o_key), 32'h3);
      ticks(1);
      keys[0] = 4'b0000;
      ticks(1);
      keys[0] = 4'b1000;
      ticks(1);
      check("bounce_held", 32'(o_key_held), 32'h1);
      keys[0] = 4'b0000;
      ticks(3);
      check("bounce_rel_pending", 32'(o_key_held), 32'h1);
      ticks(1);
      check("bounce_released", 32'(o_key_held), 32'h0);
      check("bounce_col_wrap", 32'(o_col), 32'hE);
      check("bounce_vld_cnt", 32'(vld_cnt), 32'd2);

      // Rows 0 and 3 both low on col2: lowest row wins.
      keys[0] = 4'b0100;
      keys[3] = 4'b0100;
      ticks(5);
      check("prio_vld", 32'(o_key_vld), 32'h1);
      check("prio_key", 32'(o_key), 32'h2);
      ticks(1);
      check("prio_held", 32'(o_key_held), 32'h1);
      check("prio_vld_cnt", 32'(vld_cnt), 32'd3);

      // Asynchronous reset in HOLD.
      keys[0] = 4'b0000;
      keys[3] = 4'b0000;
      rst_n = 1'b0;
      #1;
      check("arst_key", 32'(o_key), 32'h0);
      check("arst_held", 32'(o_key_held), 32'h0);
      check("arst_col", 32'(o_col), 32'hE);
      check("arst_vld", 32'(o_key_vld), 32'h0);
      clocks(2);
      rst_n = 1'b1;
      ticks(6);
      check("post_rst_col", 32'(o_col), 32'hB);
      check("post_rst_vld_cnt", 32'(vld_cnt), 32'd0);
      check("post_rst_key", 32'(o_key), 32'h0);
      check("post_rst_held", 32'(o_key_held), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/key_matrix_scan.md
KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 The block SHALL have parameter SCAN_NUM, default 32'd50000, giving clk cycles per column dwell (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter DEB_NUM, default 4'd10, giving consecutive matching samples needed for press and release acceptance.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, 50 MHz; all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_row, input, 4 bits: keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 The block SHALL have port o_col, output, 4 bits: column drive, active-low one-hot.
REQ-007 The block SHALL have port o_key, output, 4 bits: code of the last accepted key, row*4+col.
REQ-008 The block SHALL have port o_key_vld, output, 1 bit: one-clk pulse when a press is accepted.
REQ-009 The block SHALL have port o_key_held, output, 1 bit: level, high from press acceptance until release acceptance.

Function
REQ-010 i_row SHALL pass through a 2-flop synchronizer before any use; "row sample" below means the synchronized value.
REQ-011 A tick counter SHALL count 0..SCAN_NUM-1 and wrap; a one-clk tick SHALL assert when the counter equals SCAN_NUM-1; the counter SHALL never stop.
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE, HOLD, RELEASE; all sampling and transitions SHALL occur only on tick cycles.
REQ-013 SCAN: if the row sample is 4'b1111 on a tick, o_col SHALL rotate 1110->1101->1011->0111->1110; col index 0..3 SHALL follow the low bit.
REQ-014 SCAN: if any row bit is low on a tick, the FSM SHALL latch candidate = {lowest-index low row, current col}, clear the debounce count, hold o_col, and go to DEBOUNCE.
REQ-015 Multiple low rows SHALL resolve to the lowest-index low row; lower-priority keys SHALL be ignored.
REQ-016 DEBOUNCE: on each tick where the resolved code equals candidate, count SHALL increment; when count reaches DEB_NUM-1 and matches, the FSM SHALL go to HOLD, load o_key=candidate, and pulse o_key_vld for exactly one clk.
REQ-017 DEBOUNCE: any mismatching tick, including all rows high, SHALL return to SCAN, advance o_col one step, leave o_key unchanged, and emit no pulse.
REQ-018 HOLD: o_col SHALL stay frozen and o_key_held SHALL be 1; a tick with the candidate row high SHALL go to RELEASE with count cleared; other rows SHALL be ignored.
REQ-019 RELEASE: each tick with the candidate row high SHALL increment count; at DEB_NUM consecutive high ticks the FSM SHALL go to SCAN, clear o_key_held, and advance o_col.
REQ-020 RELEASE: a tick with the candidate row low SHALL return to HOLD; no new o_key_vld SHALL be emitted (bounce tolerance).
REQ-021 Press-to-vld latency SHALL be 2 clk (synchronizer) plus DEB_NUM ticks from the first sampling tick; o_key SHALL hold its value until the next accepted press.
REQ-022 Debounce count width SHALL be 4 bits; DEB_NUM=0 or 1 SHALL both mean acceptance on the first matching tick.

Reset
REQ-023 While rst_n is low, the block SHALL set state=SCAN, o_col=4'b1110, o_key=4'd0, o_key_vld=0, o_key_held=0, tick counter=0, debounce count=0, and synchronizer flops=4'b1111.
REQ-024 Reset assertion mid-DEBOUNCE, HOLD, or RELEASE SHALL abort immediately with no o_key_vld pulse; after release, scanning SHALL restart at column 0.

Verification (SCAN_NUM=4, DEB_NUM=3)
REQ-025 Scenario: idle, rows 1111 -> o_col cycles 1110,1101,1011,0111 with each value held 4 clk; o_key_vld stays 0.
REQ-026 Scenario: key row2/col1 held clean -> exactly one o_key_vld with o_key=4'd9; o_key_held=1 until release plus 3 high ticks.
REQ-027 Scenario: row pulses low for 1 tick during DEBOUNCE -> no vld; o_col advances; o_key keeps its prior value.
REQ-028 Scenario: release bounce in HOLD (high 1 tick, low, high 3 ticks) -> single vld total; o_key_held falls only after the final 3 high ticks.
REQ-029 Scenario: rows 0 and 3 both low on col 2 -> o_key=4'd2.
REQ-030 Scenario: rst_n low during HOLD -> o_key=0, o_key_held=0, o_col=1110 asynchronously; no spurious vld after rst_n rises with rows high.
